// File: rtl/updowncount_ctrl.sv
// Command sequencer for an updowncount counter: LOAD / UP_TO / DOWN_TO / BOUNCE.
// Optional macro UPDOWNCOUNT_CTRL_WRAP_EN lets targets count through the 2^n-1 -> 0 wrap.
module updowncount_ctrl #(
    parameter int n = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [n-1:0] cmd_val,
    input  logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         L,
    output logic         E,
    output logic         up_down,
    output logic         done,
    output logic         err,
    output logic [2:0]   dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so at most one command is in flight.
    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_BOUNCE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_B_UP = 3'd4,
        S_B_DN = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    state_t       state, state_n;
    logic [n-1:0] target;
    logic [n-1:0] origin;
    logic         err_r;
    logic         accept;
    logic         reject;

    assign accept    = cmd_valid && cmd_ready;
    assign R         = target;
    assign dbg_state = state;

`ifdef UPDOWNCOUNT_CTRL_WRAP_EN
    assign reject = 1'b0;
`else
    // Without wrap, a target that can only be reached by wrapping is refused.
    assign reject = ((cmd_op == OP_UP)     && (cmd_val < Q)) ||
                    ((cmd_op == OP_DOWN)   && (cmd_val > Q)) ||
                    ((cmd_op == OP_BOUNCE) && (cmd_val < Q));
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            target <= '0;
            origin <= '0;
            err_r  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                target <= cmd_val;
                origin <= Q;
                err_r  <= reject;
            end else if (state == S_FIN) begin
                err_r <= 1'b0;
            end
        end
    end

    // E compares against the registered Q, so counting stops exactly on the target.
    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        L         = 1'b0;
        E         = 1'b0;
        up_down   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (reject) begin
                        state_n = S_FIN;
                    end else begin
                        case (cmd_op)
                            OP_LOAD: state_n = S_LOAD;
                            OP_UP:   state_n = S_UP;
                            OP_DOWN: state_n = S_DOWN;
                            default: state_n = S_B_UP;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                L       = 1'b1;
                state_n = S_FIN;
            end
            S_UP, S_B_UP: begin
                up_down = 1'b1;
                E       = (Q != target);
                if (Q == target) begin
                    state_n = (state == S_UP) ? S_FIN : S_B_DN;
                end
            end
            S_DOWN: begin
                E = (Q != target);
                if (Q == target) begin
                    state_n = S_FIN;
                end
            end
            S_B_DN: begin
                E = (Q != origin);
                if (Q == origin) begin
                    state_n = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                err     = err_r;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_updowncount_ctrl.sv
// Bench for updowncount_ctrl with a behavioural updowncount counter attached.
// Expected per-cycle Q/E/up_down traces are derived from the command's arithmetic distance.
module tb_updowncount_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_val = 8'd0;
    logic [7:0] Q;
    logic [7:0] R;
    logic       cmd_ready, L, E, up_down, done, err;
    logic [2:0] dbg_state;

    int checks = 0;
    int failures = 0;

`ifdef UPDOWNCOUNT_CTRL_WRAP_EN
    bit wrap_en = 1'b1;
`else
    bit wrap_en = 1'b0;
`endif

    updowncount_ctrl #(.n(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_val(cmd_val), .Q(Q), .R(R), .L(L), .E(E),
        .up_down(up_down), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 Clock = ~Clock;

    // The attached counter: load beats enable, wraps modulo 256.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)  Q <= 8'd0;
        else if (L)   Q <= R;
        else if (E)   Q <= up_down ? Q + 8'd1 : Q - 8'd1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model results and observed traces (index 0 = cycle 1 after acceptance)
    logic [7:0] exp_q[$], obs_q[$];
    logic       exp_e[$], obs_e[$], exp_u[$], obs_u[$];
    int         m_done;
    logic       m_err;
    logic [7:0] m_final;
    int         o_done, o_l, o_busy_ready;
    logic       o_err, o_ready_after;

    task automatic push_exp(input logic [7:0] q, input logic e, input logic u);
        exp_q.push_back(q);
        exp_e.push_back(e);
        exp_u.push_back(u);
    endtask

    task automatic model(input logic [1:0] op, input logic [7:0] v, input logic [7:0] a);
        int d;
        exp_q.delete(); exp_e.delete(); exp_u.delete();
        m_err = !wrap_en && (((op == 2'd1) && (v < a)) || ((op == 2'd2) && (v > a)) ||
                             ((op == 2'd3) && (v < a)));
        if (m_err) begin
            m_done = 1;
            push_exp(a, 1'b0, 1'b0);
        end else begin
            case (op)
                2'd0: begin
                    m_done = 2;
                    push_exp(a, 1'b0, 1'b0);
                    push_exp(v, 1'b0, 1'b0);
                end
                2'd1: begin
                    d = int'(8'(v - a));
                    for (int k = 1; k <= d + 1; k++) push_exp(8'(a + k - 1), k <= d, 1'b1);
                    push_exp(v, 1'b0, 1'b0);
                    m_done = d + 2;
                end
                2'd2: begin
                    d = int'(8'(a - v));
                    for (int k = 1; k <= d + 1; k++) push_exp(8'(a - k + 1), k <= d, 1'b0);
                    push_exp(v, 1'b0, 1'b0);
                    m_done = d + 2;
                end
                default: begin
                    d = int'(8'(v - a));
                    for (int k = 1; k <= d + 1; k++) push_exp(8'(a + k - 1), k <= d, 1'b1);
                    for (int j = 0; j <= d; j++) push_exp(8'(v - j), j < d, 1'b0);
                    push_exp(a, 1'b0, 1'b0);
                    m_done = 2 * d + 3;
                end
            endcase
        end
        m_final = exp_q[exp_q.size() - 1];
    endtask

    function automatic int traj_diff();
        int nd = 0;
        if (obs_q.size() != exp_q.size()) return 1000;
        foreach (exp_q[i]) begin
            if (obs_q[i] !== exp_q[i] || obs_e[i] !== exp_e[i] || obs_u[i] !== exp_u[i]) nd++;
        end
        return nd;
    endfunction

    // Called at a falling edge; returns at the falling edge of the cycle after done.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] v);
        model(op, v, Q);
        obs_q.delete(); obs_e.delete(); obs_u.delete();
        o_done = 0; o_err = 1'b0; o_l = 0; o_busy_ready = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_val = v;
        @(posedge Clock); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_val = 8'($urandom);
        for (int k = 1; k <= 1200; k++) begin
            @(negedge Clock);
            obs_q.push_back(Q); obs_e.push_back(E); obs_u.push_back(up_down);
            o_l = o_l + int'(L);
            if (cmd_ready) o_busy_ready++;
            if (done) begin
                o_done = k;
                o_err = err;
                break;
            end
        end
        @(negedge Clock);
        o_ready_after = cmd_ready;
    endtask

    task automatic test_reset();
        #2 Resetn = 1'b0;
        #1;
        checks++; if ({cmd_ready, L, E, up_down, done, err} !== 6'b100000) begin failures++;
            $display("FAIL reset_ctrl: got %b want 100000", {cmd_ready, L, E, up_down, done, err}); end
        checks++; if (R !== 8'd0 || Q !== 8'd0) begin failures++;
            $display("FAIL reset_data: R=%0d Q=%0d want 0 0", R, Q); end
        @(negedge Clock); @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_load();
        run_cmd(2'd0, 8'd8);
        checks++; if (o_done !== 2 || o_err !== 1'b0) begin failures++;
            $display("FAIL load_done: cycle=%0d err=%b want 2 0", o_done, o_err); end
        checks++; if (Q !== 8'd8 || o_l !== 1) begin failures++;
            $display("FAIL load_q: Q=%0d Lcycles=%0d want 8 1", Q, o_l); end
        checks++; if (traj_diff() != 0 || o_ready_after !== 1'b1 || o_busy_ready != 0) begin failures++;
            $display("FAIL load_trace: diffs=%0d ready_after=%b busy_ready=%0d want 0 1 0",
                     traj_diff(), o_ready_after, o_busy_ready); end
    endtask

    task automatic test_up();
        run_cmd(2'd1, 8'd13);
        checks++; if (o_done !== 7 || o_err !== 1'b0 || Q !== 8'd13) begin failures++;
            $display("FAIL up_to_13: cycle=%0d err=%b Q=%0d want 7 0 13", o_done, o_err, Q); end
        checks++; if (traj_diff() != 0 || o_l != 0) begin failures++;
            $display("FAIL up_trace: diffs=%0d Lcycles=%0d want 0 0", traj_diff(), o_l); end
    endtask

    task automatic test_bounce();
        run_cmd(2'd3, 8'd15);
        checks++; if (o_done !== 7 || o_err !== 1'b0 || Q !== 8'd13) begin failures++;
            $display("FAIL bounce_15: cycle=%0d err=%b Q=%0d want 7 0 13", o_done, o_err, Q); end
        checks++; if (traj_diff() != 0) begin failures++;
            $display("FAIL bounce_trace: %0d differing cycles, want 0", traj_diff()); end
    endtask

    task automatic test_down_to_20();
        int want_cycle;
        logic [7:0] want_q;
        want_cycle = wrap_en ? 251 : 1;
        want_q = wrap_en ? 8'd20 : 8'd13;
        run_cmd(2'd2, 8'd20);
        checks++; if (o_done !== want_cycle || o_err !== !wrap_en || Q !== want_q) begin failures++;
            $display("FAIL down_to_20: cycle=%0d err=%b Q=%0d want %0d %b %0d",
                     o_done, o_err, Q, want_cycle, !wrap_en, want_q); end
        checks++; if (traj_diff() != 0 || o_l != 0) begin failures++;
            $display("FAIL down_trace: diffs=%0d Lcycles=%0d want 0 0", traj_diff(), o_l); end
    endtask

    task automatic test_up_equal();
        run_cmd(2'd0, 8'd13);
        run_cmd(2'd1, 8'd13);
        checks++; if (o_done !== 2 || o_err !== 1'b0 || Q !== 8'd13) begin failures++;
            $display("FAIL up_equal: cycle=%0d err=%b Q=%0d want 2 0 13", o_done, o_err, Q); end
        checks++; if (traj_diff() != 0) begin failures++;
            $display("FAIL up_equal_trace: %0d differing cycles, want 0", traj_diff()); end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] v;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) v = 8'($urandom);
            else v = 8'(Q + $urandom_range(0, 12) - 6);
            run_cmd(op, v);
            checks++; if (o_done !== m_done || o_err !== m_err || Q !== m_final) begin failures++;
                $display("FAIL rand_%0d op=%0d val=%0d: cycle=%0d err=%b Q=%0d want %0d %b %0d",
                         i, op, v, o_done, o_err, Q, m_done, m_err, m_final); end
            checks++; if (traj_diff() != 0 || o_ready_after !== 1'b1 || o_busy_ready != 0) begin failures++;
                $display("FAIL rand_trace_%0d: diffs=%0d ready_after=%b busy_ready=%0d want 0 1 0",
                         i, traj_diff(), o_ready_after, o_busy_ready); end
            checks++; if (o_l != ((op == 2'd0) ? 1 : 0)) begin failures++;
                $display("FAIL rand_load_%0d: Lcycles=%0d want %0d", i, o_l, (op == 2'd0) ? 1 : 0); end
        end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        run_cmd(2'd0, 8'd0);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_val = 8'd200;
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clock);
            if (done) seen_done++;
        end
        checks++; if (Q !== 8'd29 || E !== 1'b1) begin failures++;
            $display("FAIL mid_progress: Q=%0d E=%b want 29 1", Q, E); end
        #2 Resetn = 1'b0;
        #1;
        checks++; if ({cmd_ready, L, E, up_down, done, err} !== 6'b100000 || R !== 8'd0 || Q !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: ctrl=%b R=%0d Q=%0d want 100000 0 0",
                     {cmd_ready, L, E, up_down, done, err}, R, Q); end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            if (done) seen_done++;
        end
        Resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            if (done) seen_done++;
        end
        checks++; if (seen_done != 0 || Q !== 8'd0) begin failures++;
            $display("FAIL mid_no_done: done_pulses=%0d Q=%0d want 0 0", seen_done, Q); end
        run_cmd(2'd0, 8'd5);
        checks++; if (o_done !== 2 || o_err !== 1'b0 || Q !== 8'd5) begin failures++;
            $display("FAIL after_reset_load: cycle=%0d err=%b Q=%0d want 2 0 5", o_done, o_err, Q); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_up();
        test_bounce();
        test_down_to_20();
        test_up_equal();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updowncount_ctrl.md
# updowncount_ctrl

Command-driven sequencer for the `updowncount` up/down counter. It accepts one command at a time over a valid/ready handshake and drives the counter's `R`, `L`, `E` and `up_down` inputs. It watches the counter's `Q` output to decide when each operation is complete. It sits between a host/test sequencer and one `updowncount` instance that shares the same `Clock` and `Resetn`.

## Interface
- `n`, 8, counter width; must match the attached `updowncount` instance.
- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset; drive the same net into the counter.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  controller is idle and can accept a command.
- `cmd_op`  in  2  opcode: 00 LOAD, 01 UP_TO, 10 DOWN_TO, 11 BOUNCE.
- `cmd_val`  in  n  load value or target value.
- `Q`  in  n  counter output.
- `R`  out  n  counter load data.
- `L`  out  1  counter load strobe.
- `E`  out  1  counter count enable.
- `up_down`  out  1  counter direction; 1 means up.
- `done`  out  1  one-cycle pulse marking the end of a command.
- `err`  out  1  qualifies `done`; high when the command was rejected.

## Operation
- Counter contract: on each rising edge, `L` forces `Q<=R`; otherwise `E` steps `Q` by ±1 modulo 2^n. `L` takes priority over `E`.
- Registers:
  - `state`
  - `op`
  - `target[n-1:0]`
  - `origin[n-1:0]`
  - `err_r`
- Acceptance: a command is accepted when `cmd_valid && cmd_ready` at an edge. At that edge `target<=cmd_val` and `origin<=Q`. `cmd_val` and `cmd_op` are ignored when not accepted.
- States:
  - IDLE: `cmd_ready=1`. On accept, go to LOAD, UP, DOWN or B_UP according to `cmd_op`. Go to FIN with `err_r=1` if the range check fails (see Configuration).
  - LOAD: `L=1`, `R=target`, for one cycle, then go to FIN.
  - UP: `up_down=1`, `E=(Q!=target)`. When `Q==target`, go to FIN.
  - DOWN: `up_down=0`, `E=(Q!=target)`. When `Q==target`, go to FIN.
  - B_UP: behaves as UP. When `Q==target`, go to B_DN.
  - B_DN: `up_down=0`, `E=(Q!=origin)`. When `Q==origin`, go to FIN.
  - FIN: `done=1`, `err=err_r`, `cmd_ready=0`. Next state is IDLE, and `err_r` clears.
- `R` always outputs `target`. `L=0` outside LOAD. `E=0` outside UP, DOWN, B_UP and B_DN.
- `up_down` is 1 only in UP and B_UP. In all other states it is 0.
- `E` is combinational from `state` and the counter's registered `Q`, so the counter never overshoots the target.
- A target equal to the current `Q` is legal. The controller spends zero count cycles and still reports `done` with `err=0`.

## Timing
- Cycle numbering: cycle k is the k-th cycle after the acceptance edge.
- LOAD: `L=1` in cycle 1. `Q==cmd_val` and `done=1` in cycle 2. `cmd_ready=1` in cycle 3.
- UP_TO from a to b, with d = (b-a) mod 2^n:
  - `E=1` in cycles 1..d.
  - `E=0` in cycle d+1.
  - `done` in cycle d+2.
  - `cmd_ready` in cycle d+3.
- DOWN_TO: same timing as UP_TO with d = (a-b) mod 2^n.
- BOUNCE from a to b, with d = (b-a) mod 2^n:
  - Up phase: `E=1` in cycles 1..d, then one idle-E cycle.
  - Down phase: `E=1` for d cycles, then one idle-E cycle.
  - `done` in cycle 2d+3.
- Rejected command: `done=1`, `err=1` in cycle 1. `E` and `L` are never asserted.
- Back-to-back throughput: one command per (latency + 1) cycles. `cmd_ready` is low from acceptance through FIN.
- Reset (async, any time, including mid-command): state goes to IDLE immediately.
  - Values during and after reset: `L=E=up_down=done=err=0`, `R=0`, `cmd_ready=1`.
  - `target`, `origin` and `err_r` clear.
  - A command in progress is discarded and no `done` is issued for it.

## Configuration
- Macro: `UPDOWNCOUNT_CTRL_WRAP_EN`.
- When defined, every target is accepted. UP and DOWN count through the 2^n-1 to 0 wrap point; for example, UP_TO from 250 to 4 with n=8 takes d=10.
- When undefined, the following commands are rejected at acceptance (FIN with `err=1`, counter untouched):
  - UP_TO with `cmd_val < Q`.
  - DOWN_TO with `cmd_val > Q`.
  - BOUNCE with `cmd_val < Q`.
- LOAD is never rejected.

## Test plan
- Reset, then LOAD 8 → `L` high for one cycle, `Q=8` and `done` in cycle 2, `err=0`.
- With `Q=8`, UP_TO 13 → `E=1` and `up_down=1` for 5 cycles, `Q=13`, `done` in cycle 7.
- With `Q=13`, BOUNCE 15 → Q follows 13,14,15,14,13; `done` in cycle 7; `origin` returned to 13.
- With `Q=13`, DOWN_TO 20:
  - Without the macro: `done`+`err` in cycle 1, `Q` stays 13.
  - With the macro: 249 down-steps, `Q=20`, `err=0`.
- With `Q=13`, UP_TO 13 → `E` never high, `done` in cycle 2, `err=0`.
- Start UP_TO 200 from 0 and drop `Resetn` in cycle 30 → all outputs go to reset values immediately, `Q=0`, no `done`. After reset, a new LOAD 5 is accepted.
